// File: rtl/fir_param_pkg.sv
// ----------------------------------------------------------------------------
// fir_param_pkg
// Shared types and constants for the FIR coefficient loader.
//   - state_e        : loader FSM state encoding
//   - REG_AW         : register-bus address width
//   - REG_IDLE_ADDR  : address driven while no transaction is in flight
//   - ERR_*          : err_code values
// ----------------------------------------------------------------------------
package fir_param_pkg;

    localparam int unsigned REG_AW = 12;
    localparam logic [REG_AW-1:0] REG_IDLE_ADDR = 12'hFFF;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_CMP  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_FIN   = 3'd6,
        ST_ERR   = 3'd7
    } state_e;

endpackage

// File: rtl/reg_bus_timer.sv
// ----------------------------------------------------------------------------
// reg_bus_timer
// Wait-cycle counter for one register-bus transaction.
// Ports:
//   i_clk      clock
//   i_rst      asynchronous active-high reset
//   i_clr      synchronous clear (priority over i_en)
//   i_en       count one wait cycle
//   o_expired  high in the wait cycle that brings the count to TIMEOUT
// ----------------------------------------------------------------------------
module reg_bus_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // The cycle holding count TIMEOUT-1 is the TIMEOUT-th wait cycle, so the
    // caller leaves the transaction on that edge.
    assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_param_loader.sv
// ----------------------------------------------------------------------------
// fir_param_loader
// Register-bus initiator that copies tap_len coefficients from a synchronous
// ROM into fir_mc at register addresses 0..tap_len-1, optionally reading each
// word back to confirm it.
// Ports:
//   i_clk, i_rst          register clock, async active-high reset
//   i_start, i_abort      load request (IDLE only) / synchronous abort
//   i_tap_len             word count, sampled on accepted start
//   o_coef_addr/o_coef_rd ROM address and read strobe (data next cycle)
//   i_coef_data           ROM data
//   o_reg_addr/o_reg_wr/o_reg_rd/o_reg_writedata   bus request
//   i_reg_ready/i_reg_readdata                     bus completion / read data
//   o_busy, o_done        not-IDLE flag, one-cycle success pulse
//   o_err, o_err_code, o_err_addr   sticky error status
// ----------------------------------------------------------------------------
module fir_param_loader
    import fir_param_pkg::*;
#(
    parameter int unsigned MAX_TAPS = 256,
    parameter int unsigned CAW      = 8,
    parameter bit          VERIFY   = 1'b1,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [11:0]       i_tap_len,
    output logic [CAW-1:0]    o_coef_addr,
    output logic              o_coef_rd,
    input  logic [31:0]       i_coef_data,
    output logic [11:0]       o_reg_addr,
    output logic              o_reg_wr,
    output logic              o_reg_rd,
    input  logic              i_reg_ready,
    output logic [31:0]       o_reg_writedata,
    input  logic [31:0]       i_reg_readdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic [11:0]       o_err_addr
);

    localparam logic [REG_AW-1:0] MAX_LEN = REG_AW'(MAX_TAPS);

    state_e            r_state;
    logic [REG_AW-1:0] r_idx;
    logic [REG_AW-1:0] r_len;
    logic [REG_AW-1:0] r_reg_addr;
    logic              r_reg_wr;
    logic              r_reg_rd;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic [REG_AW-1:0] r_err_addr;

    state_e            w_state_nxt;
    logic [REG_AW-1:0] w_idx_nxt;
    logic [REG_AW-1:0] w_len_nxt;
    logic [REG_AW-1:0] w_reg_addr_nxt;
    logic              w_reg_wr_nxt;
    logic              w_reg_rd_nxt;
    logic [31:0]       w_wdata_nxt;
    logic              w_err_nxt;
    logic [1:0]        w_err_code_nxt;
    logic [REG_AW-1:0] w_err_addr_nxt;

    logic              w_in_bus;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_expired;
    logic [REG_AW-1:0] w_idx_inc;

    // Timer runs only while a bus request is waiting; a completing ready
    // clears it so a READ following a WRITE starts from zero.
    assign w_in_bus  = (r_state == ST_WRITE) || (r_state == ST_READ);
    assign w_tmr_clr = !w_in_bus || i_reg_ready;
    assign w_tmr_en  = w_in_bus && !i_reg_ready;
    assign w_idx_inc = r_idx + 12'd1;

    reg_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_len_nxt      = r_len;
        w_reg_addr_nxt = r_reg_addr;
        w_reg_wr_nxt   = r_reg_wr;
        w_reg_rd_nxt   = r_reg_rd;
        w_wdata_nxt    = r_wdata;
        w_err_nxt      = r_err;
        w_err_code_nxt = r_err_code;
        w_err_addr_nxt = r_err_addr;

        if (i_abort) begin
            // Abort silently parks the bus; error status is left untouched.
            w_state_nxt    = ST_IDLE;
            w_reg_wr_nxt   = 1'b0;
            w_reg_rd_nxt   = 1'b0;
            w_reg_addr_nxt = REG_IDLE_ADDR;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_err_nxt      = 1'b0;
                        w_err_code_nxt = ERR_NONE;
                        w_err_addr_nxt = '0;
                        w_idx_nxt      = '0;
                        w_len_nxt      = i_tap_len;
                        if (i_tap_len == '0) begin
                            w_state_nxt = ST_FIN;
                        end else if (i_tap_len > MAX_LEN) begin
                            w_state_nxt    = ST_ERR;
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = ERR_LEN;
                            w_err_addr_nxt = i_tap_len;
                        end else begin
                            w_state_nxt = ST_FETCH;
                        end
                    end
                end

                ST_FETCH: begin
                    w_state_nxt = ST_LATCH;
                end

                ST_LATCH: begin
                    // ROM data from the FETCH strobe is valid in this cycle.
                    w_wdata_nxt    = i_coef_data;
                    w_reg_addr_nxt = r_idx;
                    w_reg_wr_nxt   = 1'b1;
                    w_state_nxt    = ST_WRITE;
                end

                ST_WRITE: begin
                    if (i_reg_ready) begin
                        w_reg_wr_nxt = 1'b0;
                        if (VERIFY) begin
                            w_reg_rd_nxt = 1'b1;
                            w_state_nxt  = ST_READ;
                        end else begin
                            w_reg_addr_nxt = REG_IDLE_ADDR;
                            w_state_nxt    = ST_NEXT;
                        end
                    end else if (w_expired) begin
                        w_reg_wr_nxt   = 1'b0;
                        w_reg_addr_nxt = REG_IDLE_ADDR;
                        w_state_nxt    = ST_ERR;
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_TMO;
                        w_err_addr_nxt = r_reg_addr;
                    end
                end

                ST_READ: begin
                    if (i_reg_ready) begin
                        w_reg_rd_nxt   = 1'b0;
                        w_reg_addr_nxt = REG_IDLE_ADDR;
                        if (i_reg_readdata != r_wdata) begin
                            w_state_nxt    = ST_ERR;
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = ERR_CMP;
                            w_err_addr_nxt = r_reg_addr;
                        end else begin
                            w_state_nxt = ST_NEXT;
                        end
                    end else if (w_expired) begin
                        w_reg_rd_nxt   = 1'b0;
                        w_reg_addr_nxt = REG_IDLE_ADDR;
                        w_state_nxt    = ST_ERR;
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_TMO;
                        w_err_addr_nxt = r_reg_addr;
                    end
                end

                ST_NEXT: begin
                    w_idx_nxt = w_idx_inc;
                    if (w_idx_inc == r_len) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end

                ST_FIN: begin
                    w_state_nxt = ST_IDLE;
                end

                ST_ERR: begin
                    w_state_nxt = ST_IDLE;
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_len      <= '0;
            r_reg_addr <= REG_IDLE_ADDR;
            r_reg_wr   <= 1'b0;
            r_reg_rd   <= 1'b0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_err_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_len      <= w_len_nxt;
            r_reg_addr <= w_reg_addr_nxt;
            r_reg_wr   <= w_reg_wr_nxt;
            r_reg_rd   <= w_reg_rd_nxt;
            r_wdata    <= w_wdata_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            r_err_addr <= w_err_addr_nxt;
        end
    end

    assign o_coef_addr     = CAW'(r_idx);
    assign o_coef_rd       = (r_state == ST_FETCH);
    assign o_reg_addr      = r_reg_addr;
    assign o_reg_wr        = r_reg_wr;
    assign o_reg_rd        = r_reg_rd;
    assign o_reg_writedata = r_wdata;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_done          = (r_state == ST_FIN);
    assign o_err           = r_err;
    assign o_err_code      = r_err_code;
    assign o_err_addr      = r_err_addr;

endmodule
